led_blink_ctrl: RTL and testbench

Downstream LED output stage behind the AXI4-Lite LED register slave. It consumes the slave's decoded configuration fields plus a write strobe and drives the board LED pins. It supports static, blink, rotating-shift and PWM modes, all paced by a programmable prescaler. All outputs are registered and there is no bus interface of its own.

---
 rtl/led_pkg.sv | 18 +
 rtl/led_prescaler.sv | 35 +++
 rtl/led_blink_ctrl.sv | 132 +++++++++++++
 tb/tb_led_blink_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types for the LED output stage: drive modes, controller states and PWM width.
package led_pkg;

  localparam int PWM_W = 8;

  typedef enum logic [1:0] {
    LED_STATIC = 2'd0,
    LED_BLINK  = 2'd1,
    LED_SHIFT  = 2'd2,
    LED_PWM    = 2'd3
  } led_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } led_state_e;

endpackage

// File: rtl/led_prescaler.sv
// Free-running tick generator: counts 0..prescale, exposes the wrap condition as
// a same-cycle step and as a registered one-cycle tick.
module led_prescaler #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  step,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt_q;

  // clear outranks the wrap so a reload never applies a step
  assign step = enable && !clear && (cnt_q == prescale);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else if (clear) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else if (enable) begin
      tick  <= step;
      cnt_q <= step ? '0 : cnt_q + 1'b1;
    end else begin
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/led_blink_ctrl.sv
// LED output stage: shadow config, IDLE/RUN controller and static/blink/shift/PWM mux.
// Optional build macro LED_BREATHE_EN adds a triangular duty sweep in PWM mode.
//
// state   | meaning
// ST_IDLE | after reset, LEDs off, prescaler stopped
// ST_RUN  | config loaded, prescaler running, LEDs driven by mode
module led_blink_ctrl
  import led_pkg::*;
#(
  parameter int LED_WIDTH  = 4,
  parameter int PRESCALE_W = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  cfg_load,
  input  logic [1:0]            cfg_mode,
  input  logic [PRESCALE_W-1:0] cfg_prescale,
  input  logic [LED_WIDTH-1:0]  cfg_pattern,
  input  logic [PWM_W-1:0]      cfg_duty,
  output logic [LED_WIDTH-1:0]  led_out,
  output logic                  tick,
  output logic                  running
);

  led_state_e            state_q;
  led_mode_e             mode_q;
  logic [PRESCALE_W-1:0] prescale_q;
  logic [LED_WIDTH-1:0]  pattern_q;
  logic                  phase_q;
  logic [LED_WIDTH-1:0]  rotate_q;
  logic [PWM_W-1:0]      pwm_cnt_q;
  logic [PWM_W-1:0]      duty_eff;
  logic [LED_WIDTH-1:0]  led_next;
  logic                  step;

  assign running = (state_q == ST_RUN);

  led_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
    .ACLK     (ACLK),
    .ARESET   (ARESET),
    .enable   (running),
    .clear    (cfg_load),
    .prescale (prescale_q),
    .step     (step),
    .tick     (tick)
  );

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= ST_IDLE;
      mode_q     <= LED_STATIC;
      prescale_q <= '0;
      pattern_q  <= '0;
      phase_q    <= 1'b0;
      rotate_q   <= '0;
      pwm_cnt_q  <= '0;
    end else if (cfg_load) begin
      state_q    <= ST_RUN;
      mode_q     <= led_mode_e'(cfg_mode);
      prescale_q <= cfg_prescale;
      pattern_q  <= cfg_pattern;
      phase_q    <= 1'b0;
      rotate_q   <= cfg_pattern;
      pwm_cnt_q  <= '0;
    end else if (step) begin
      phase_q    <= ~phase_q;
      rotate_q   <= {rotate_q[LED_WIDTH-2:0], rotate_q[LED_WIDTH-1]};
      pwm_cnt_q  <= pwm_cnt_q + 1'b1;
    end
  end

`ifdef LED_BREATHE_EN
  logic [PWM_W-1:0] duty_sweep_q;
  logic             dir_down_q;
  logic [PWM_W-1:0] duty_step;

  assign duty_eff  = duty_sweep_q;
  assign duty_step = dir_down_q ? duty_sweep_q - 1'b1 : duty_sweep_q + 1'b1;

  // sweep advances once per full PWM period, turning around at either rail
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      duty_sweep_q <= '0;
      dir_down_q   <= 1'b0;
    end else if (cfg_load) begin
      duty_sweep_q <= cfg_duty;
      dir_down_q   <= (cfg_duty == {PWM_W{1'b1}});
    end else if (step && (pwm_cnt_q == {PWM_W{1'b1}})) begin
      duty_sweep_q <= duty_step;
      if (duty_step == {PWM_W{1'b1}}) begin
        dir_down_q <= 1'b1;
      end else if (duty_step == '0) begin
        dir_down_q <= 1'b0;
      end
    end
  end
`else
  logic [PWM_W-1:0] duty_q;

  assign duty_eff = duty_q;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      duty_q <= '0;
    end else if (cfg_load) begin
      duty_q <= cfg_duty;
    end
  end
`endif

  always_comb begin
    led_next = '0;
    case (mode_q)
      LED_STATIC: led_next = pattern_q;
      LED_BLINK:  led_next = phase_q ? '0 : pattern_q;
      LED_SHIFT:  led_next = rotate_q;
      LED_PWM:    led_next = (pwm_cnt_q < duty_eff) ? pattern_q : '0;
      default:    led_next = '0;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      led_out <= '0;
    end else if (state_q == ST_RUN) begin
      led_out <= led_next;
    end else begin
      led_out <= '0;
    end
  end

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Self-checking bench for led_blink_ctrl: directed vector table, corner sequences and a
// randomized run against a tick-count reference model (honours LED_BREATHE_EN).
module tb_led_blink_ctrl;

  localparam int LW = 4;
  localparam int PW = 16;

  logic          tb_ACLK = 1'b0;
  logic          ARESET;
  logic          cfg_load;
  logic [1:0]    cfg_mode;
  logic [PW-1:0] cfg_prescale;
  logic [LW-1:0] cfg_pattern;
  logic [7:0]    cfg_duty;
  logic [LW-1:0] led_out;
  logic          tick;
  logic          running;

  always #5 tb_ACLK = ~tb_ACLK;

  led_blink_ctrl #(.LED_WIDTH(LW), .PRESCALE_W(PW)) dut (
    .ACLK         (tb_ACLK),
    .ARESET       (ARESET),
    .cfg_load     (cfg_load),
    .cfg_mode     (cfg_mode),
    .cfg_prescale (cfg_prescale),
    .cfg_pattern  (cfg_pattern),
    .cfg_duty     (cfg_duty),
    .led_out      (led_out),
    .tick         (tick),
    .running      (running)
  );

  int checks = 0;
  int errors = 0;

  // reference state: config captured at the last load and edges elapsed since it
  bit            m_run  = 1'b0;
  int            m_mode = 0;
  int            m_p    = 0;
  logic [LW-1:0] m_pat  = '0;
  int            m_duty = 0;
  longint        m_n    = 0;
  logic [LW-1:0] exp_led;
  bit            exp_tick;
  bit            exp_run;

  function automatic logic [LW-1:0] rotl(input logic [LW-1:0] v, input int r);
    logic [LW-1:0] res;
    for (int i = 0; i < LW; i++) res[i] = v[(i - r + LW) % LW];
    return res;
  endfunction

  function automatic int duty_after(input longint wraps);
`ifdef LED_BREATHE_EN
    longint pos;
    pos = (m_duty + wraps) % 510;
    return (pos <= 255) ? int'(pos) : int'(510 - pos);
`else
    return (wraps >= 0) ? m_duty : m_duty;
`endif
  endfunction

  // LED value driven from the state reached after m_n edges since the load
  function automatic logic [LW-1:0] model_led();
    longint t;
    t = m_n / (m_p + 1);
    case (m_mode)
      0: return m_pat;
      1: return (t % 2 == 1) ? '0 : m_pat;
      2: return rotl(m_pat, int'(t % LW));
      default: return ((t % 256) < duty_after(t / 256)) ? m_pat : '0;
    endcase
  endfunction

  task automatic model_edge(input bit rst, input bit ld, input int mode, input int p,
                            input logic [LW-1:0] pat, input int duty);
    if (rst) begin
      m_run = 0; m_mode = 0; m_p = 0; m_pat = '0; m_duty = 0; m_n = 0;
      exp_led = '0; exp_tick = 0; exp_run = 0;
    end else begin
      exp_led = m_run ? model_led() : '0;
      if (ld) begin
        m_run = 1; m_mode = mode; m_p = p; m_pat = pat; m_duty = duty; m_n = 0;
        exp_tick = 0;
      end else if (m_run) begin
        m_n++;
        exp_tick = (m_n % (m_p + 1) == 0);
      end else begin
        exp_tick = 0;
      end
      exp_run = m_run;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: actual %0h required %0h", name, $time, act, req);
    end
  endtask

  task automatic cycle(input bit rst, input bit ld, input int mode, input int p,
                       input logic [LW-1:0] pat, input int duty);
    ARESET       = rst;
    cfg_load     = ld;
    cfg_mode     = mode[1:0];
    cfg_prescale = p[PW-1:0];
    cfg_pattern  = pat;
    cfg_duty     = duty[7:0];
    @(posedge tb_ACLK);
    #1;
    model_edge(rst, ld, mode, p, pat, duty);
    check("model_led", 32'(led_out), 32'(exp_led));
    check("model_tick", 32'(tick), 32'(exp_tick));
    check("model_running", 32'(running), 32'(exp_run));
  endtask

  task automatic idle();
    cycle(0, 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 9)), LW'($urandom), int'($urandom_range(0, 255)));
  endtask

  typedef struct {
    bit            rst;
    bit            ld;
    int            mode;
    int            p;
    logic [LW-1:0] pat;
    int            duty;
    logic [LW-1:0] e_led;
    bit            e_tick;
    bit            e_run;
  } vec_t;

  vec_t tbl[12];
  int   on_cnt;
  int   tick_cnt;
  logic [LW-1:0] shift_seq[5];

  initial begin
    tbl[0]  = '{1, 0, 0, 0, 4'h0, 0, 4'h0, 0, 0};
    tbl[1]  = '{0, 1, 0, 0, 4'hA, 0, 4'h0, 0, 1};
    tbl[2]  = '{0, 0, 0, 0, 4'h0, 0, 4'hA, 1, 1};
    tbl[3]  = '{0, 0, 2, 7, 4'h5, 9, 4'hA, 1, 1};
    tbl[4]  = '{0, 1, 1, 1, 4'hF, 0, 4'hA, 0, 1};
    tbl[5]  = '{0, 0, 0, 0, 4'h0, 0, 4'hF, 0, 1};
    tbl[6]  = '{0, 0, 0, 0, 4'h0, 0, 4'hF, 1, 1};
    tbl[7]  = '{0, 0, 0, 0, 4'h0, 0, 4'h0, 0, 1};
    tbl[8]  = '{0, 0, 0, 0, 4'h0, 0, 4'h0, 1, 1};
    tbl[9]  = '{0, 0, 0, 0, 4'h0, 0, 4'hF, 0, 1};
    tbl[10] = '{1, 1, 3, 0, 4'hF, 200, 4'h0, 0, 0};
    tbl[11] = '{0, 0, 0, 0, 4'h0, 0, 4'h0, 0, 0};

    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].rst, tbl[i].ld, tbl[i].mode, tbl[i].p, tbl[i].pat, tbl[i].duty);
      check($sformatf("vec%0d_led", i), 32'(led_out), 32'(tbl[i].e_led));
      check($sformatf("vec%0d_tick", i), 32'(tick), 32'(tbl[i].e_tick));
      check($sformatf("vec%0d_running", i), 32'(running), 32'(tbl[i].e_run));
    end

    // no load after reset: nothing runs
    cycle(1, 0, 0, 0, '0, 0);
    tick_cnt = 0; on_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      idle();
      tick_cnt += int'(tick);
      on_cnt   += (led_out != '0) ? 1 : 0;
    end
    check("idle_ticks", 32'(tick_cnt), 32'd0);
    check("idle_led_cycles", 32'(on_cnt), 32'd0);
    check("idle_running", 32'(running), 32'd0);

    // shift rotation and restart on reload
    shift_seq[0] = 4'b0001; shift_seq[1] = 4'b0010; shift_seq[2] = 4'b0100;
    shift_seq[3] = 4'b1000; shift_seq[4] = 4'b0001;
    cycle(0, 1, 2, 0, 4'b0001, 0);
    for (int i = 0; i < 5; i++) begin
      idle();
      check($sformatf("shift_step%0d", i), 32'(led_out), 32'(shift_seq[i]));
    end
    cycle(0, 1, 2, 0, 4'b0001, 0);
    check("shift_reload_edge", 32'(led_out), 32'(4'b0010));
    idle();
    check("shift_restart", 32'(led_out), 32'(4'b0001));

    // PWM duty counts over one period
    cycle(0, 1, 3, 0, 4'hF, 64);
    on_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      idle();
      on_cnt += (led_out == 4'hF) ? 1 : 0;
    end
    check("pwm_duty64_on", 32'(on_cnt), 32'd64);
    cycle(0, 1, 3, 0, 4'hF, 0);
    on_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      idle();
      on_cnt += (led_out != '0) ? 1 : 0;
    end
    check("pwm_duty0_on", 32'(on_cnt), 32'd0);

`ifdef LED_BREATHE_EN
    cycle(0, 1, 3, 0, 4'hF, 254);
    for (int w = 0; w < 3; w++) begin
      on_cnt = 0;
      for (int i = 0; i < 256; i++) begin
        idle();
        on_cnt += (led_out == 4'hF) ? 1 : 0;
      end
      check($sformatf("breathe_window%0d", w), 32'(on_cnt), (w == 1) ? 32'd255 : 32'd254);
    end
    cycle(1, 0, 0, 0, '0, 0);
    check("breathe_reset_led", 32'(led_out), 32'd0);
    check("breathe_reset_running", 32'(running), 32'd0);
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        cycle(1, $urandom_range(0, 1) == 1, 3, 0, 4'hF, 255);
      end else if ($urandom_range(0, 39) == 0) begin
        cycle(0, 1, int'($urandom_range(0, 3)),
              ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 4)),
              LW'($urandom), int'($urandom_range(0, 255)));
      end else begin
        idle();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
